// File: rtl/rx_session_ctrl.sv
// -----------------------------------------------------------------------------
// rx_session_ctrl
//
// Groups bytes from the UART receiver into fixed-length packets. It hands each
// packet to the consumer over a valid/ready handshake. A partial packet is
// dropped when the line stays idle for TIMEOUT_S seconds. The timeout is
// counted exactly on sys_clk: a prescaler counts CLK_RATE cycles per second,
// and a seconds counter counts TIMEOUT_S seconds.
//
// Ports
//   sys_clk        in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   rx_valid       in   one-cycle strobe, a byte is on rx_data
//   rx_data        in   received byte
//   rx_busy        in   receiver is mid-frame (counts as line activity)
//   pkt_ready      in   consumer accepts the packet
//   rx_enable      out  enables the UART receiver (low while a packet waits)
//   pkt_valid      out  packet available on pkt_data
//   pkt_data       out  packet, first byte in [7:0]
//   byte_count     out  bytes collected in the current session
//   session_active out  high while collecting
//   timeout        out  one-cycle pulse, partial packet dropped
//   overrun        out  one-cycle pulse, byte arrived while delivering
// -----------------------------------------------------------------------------
module rx_session_ctrl #(
    parameter int CLK_RATE  = 50_000_000,
    parameter int TIMEOUT_S = 60,
    parameter int PKT_BYTES = 4,
    localparam int CNT_W    = $clog2(PKT_BYTES + 1)
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   rx_busy,
    input  logic                   pkt_ready,
    output logic                   rx_enable,
    output logic                   pkt_valid,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic [CNT_W-1:0]       byte_count,
    output logic                   session_active,
    output logic                   timeout,
    output logic                   overrun
);

    // A prescaler of CLK_RATE=1 would have zero width; keep at least one bit.
    localparam int PRE_W = (CLK_RATE > 1) ? $clog2(CLK_RATE) : 1;
    localparam int SEC_W = $clog2(TIMEOUT_S + 1);

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_RATE - 1);
    localparam logic [SEC_W-1:0] SEC_MAX   = SEC_W'(TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PKT_BYTES - 1);
    localparam logic [CNT_W-1:0] ONE_BYTE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DELIVER
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] presc;
    logic [SEC_W-1:0] secs;

    // NOTE: all state and outputs are written with non-blocking assignments in
    // one clocked block, so every read inside it sees the pre-edge value.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rx_enable      <= 1'b1;
            pkt_valid      <= 1'b0;
            // NOTE: the packet buffer is reset too, so pkt_data reads zero
            // after reset rather than stale or X contents.
            pkt_data       <= '0;
            byte_count     <= '0;
            session_active <= 1'b0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            presc          <= '0;
            secs           <= '0;
        end else begin
            // Pulse outputs default low and are raised only for one cycle.
            timeout <= 1'b0;
            overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    presc <= '0;
                    secs  <= '0;
                    if (rx_valid) begin
                        pkt_data[7:0] <= rx_data;
                        byte_count    <= ONE_BYTE;
                        if (PKT_BYTES == 1) begin
                            state     <= S_DELIVER;
                            rx_enable <= 1'b0;
                            pkt_valid <= 1'b1;
                        end else begin
                            state          <= S_COLLECT;
                            session_active <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (rx_valid) begin
                        // Byte lanes are selected by comparison so that no
                        // computed part-select index is needed.
                        for (int i = 0; i < PKT_BYTES; i++) begin
                            if (byte_count == CNT_W'(i)) begin
                                pkt_data[i*8 +: 8] <= rx_data;
                            end
                        end
                        byte_count <= byte_count + ONE_BYTE;
                        presc      <= '0;
                        secs       <= '0;
                        if (byte_count == LAST_IDX) begin
                            state          <= S_DELIVER;
                            session_active <= 1'b0;
                            rx_enable      <= 1'b0;
                            pkt_valid      <= 1'b1;
                        end
                    end else if (rx_busy) begin
                        // A frame in progress also counts as activity.
                        presc <= '0;
                        secs  <= '0;
                    end else if (presc == PRE_MAX) begin
                        if (secs == SEC_MAX) begin
                            // Idle for TIMEOUT_S*CLK_RATE cycles: drop the
                            // partial packet.
                            timeout        <= 1'b1;
                            state          <= S_IDLE;
                            session_active <= 1'b0;
                            byte_count     <= '0;
                            presc          <= '0;
                            secs           <= '0;
                        end else begin
                            presc <= '0;
                            secs  <= secs + SEC_W'(1);
                        end
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end

                S_DELIVER: begin
                    presc <= '0;
                    secs  <= '0;
                    // A byte here has nowhere to go. This includes the
                    // handshake cycle, so it never starts a new packet.
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (pkt_valid && pkt_ready) begin
                        state      <= S_IDLE;
                        pkt_valid  <= 1'b0;
                        byte_count <= '0;
                        rx_enable  <= 1'b1;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    rx_enable      <= 1'b1;
                    pkt_valid      <= 1'b0;
                    session_active <= 1'b0;
                    byte_count     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_session_ctrl
//
// Self-checking bench for rx_session_ctrl with CLK_RATE=10, TIMEOUT_S=3 and
// PKT_BYTES=4. A reference model keeps the collected bytes in a queue. It
// measures idle time as a plain count of cycles since the last activity. The
// model is compared with the DUT every cycle. Directed scenarios cover
// capture, backpressure, timeout, the timeout boundary and reset. They are
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_rx_session_ctrl;

    localparam int CLK_RATE  = 10;
    localparam int TIMEOUT_S = 3;
    localparam int PKT_BYTES = 4;
    localparam int IDLE_LIM  = CLK_RATE * TIMEOUT_S;
    localparam int CNT_W     = $clog2(PKT_BYTES + 1);

    logic                   sys_clk = 1'b0;
    logic                   rst_n   = 1'b0;
    logic                   rx_valid = 1'b0;
    logic [7:0]             rx_data  = '0;
    logic                   rx_busy  = 1'b0;
    logic                   pkt_ready = 1'b0;
    logic                   rx_enable;
    logic                   pkt_valid;
    logic [8*PKT_BYTES-1:0] pkt_data;
    logic [CNT_W-1:0]       byte_count;
    logic                   session_active;
    logic                   timeout;
    logic                   overrun;

    int n_checks = 0;
    int n_errors = 0;

    rx_session_ctrl #(
        .CLK_RATE (CLK_RATE),
        .TIMEOUT_S(TIMEOUT_S),
        .PKT_BYTES(PKT_BYTES)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_busy       (rx_busy),
        .pkt_ready     (pkt_ready),
        .rx_enable     (rx_enable),
        .pkt_valid     (pkt_valid),
        .pkt_data      (pkt_data),
        .byte_count    (byte_count),
        .session_active(session_active),
        .timeout       (timeout),
        .overrun       (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                      m_deliver;
    byte unsigned            m_q[$];
    int                      m_idle;
    bit                      m_timeout;
    bit                      m_overrun;
    logic [8*PKT_BYTES-1:0]  m_pkt;

    function automatic void m_reset();
        m_deliver = 0;
        m_q.delete();
        m_idle    = 0;
        m_timeout = 0;
        m_overrun = 0;
        m_pkt     = '0;
    endfunction

    function automatic void m_add_byte(input byte unsigned d);
        m_pkt[m_q.size()*8 +: 8] = d;
        m_q.push_back(d);
        m_idle = 0;
        if (m_q.size() == PKT_BYTES) m_deliver = 1;
    endfunction

    // One clock edge of behaviour, given the inputs seen at that edge.
    function automatic void m_step(input bit v, input byte unsigned d, input bit b, input bit r);
        m_timeout = 0;
        m_overrun = 0;
        if (m_deliver) begin
            if (v) m_overrun = 1;
            if (r) begin
                m_deliver = 0;
                m_q.delete();
            end
        end else if (m_q.size() == 0) begin
            if (v) m_add_byte(d);
        end else begin
            if (v) begin
                m_add_byte(d);
            end else if (b) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == IDLE_LIM) begin
                    m_timeout = 1;
                    m_q.delete();
                    m_idle = 0;
                end
            end
        end
    endfunction

    // Advance one cycle and compare every output with the model.
    task automatic tick();
        @(posedge sys_clk);
        if (!rst_n) m_reset();
        else        m_step(rx_valid, rx_data, rx_busy, pkt_ready);
        #1;
        check("rx_enable",      64'(rx_enable),      64'(!m_deliver));
        check("pkt_valid",      64'(pkt_valid),      64'(m_deliver));
        check("byte_count",     64'(byte_count),     64'(m_q.size()));
        check("session_active", 64'(session_active), 64'(!m_deliver && m_q.size() > 0));
        check("timeout",        64'(timeout),        64'(m_timeout));
        check("overrun",        64'(overrun),        64'(m_overrun));
        if (m_deliver || !rst_n) check("pkt_data", 64'(pkt_data), 64'(m_pkt));
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_busy  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    // Cycles from the last activity (counted as 1 for the cycle just after it)
    // until timeout is seen, bounded so a missing pulse cannot hang the run.
    task automatic wait_timeout(output int cnt);
        cnt = 1;
        while (!timeout && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_enable"},  64'(rx_enable),      64'(1));
        check({tag, "_pkt_valid"},  64'(pkt_valid),      64'(0));
        check({tag, "_pkt_data"},   64'(pkt_data),       64'(0));
        check({tag, "_byte_count"}, 64'(byte_count),     64'(0));
        check({tag, "_session"},    64'(session_active), 64'(0));
        check({tag, "_timeout"},    64'(timeout),        64'(0));
        check({tag, "_overrun"},    64'(overrun),        64'(0));
    endtask

    // Assert reset between edges, look at outputs at once, then release.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        rx_valid = 1'b0;
        rx_busy  = 1'b0;
        tick();
        tick();
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick();
        check({tag, "_rx_enable_after"}, 64'(rx_enable), 64'(1));
    endtask

    int cnt;
    int ovr;
    bit last_v;

    initial begin
        m_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge sys_clk);
        rst_n = 1'b1;
        idle(2);

        // 1. Packet capture with the consumer always ready.
        pkt_ready = 1'b1;
        send_byte(8'h11); check("t1_count1", 64'(byte_count), 64'(1)); idle(4);
        send_byte(8'h22); check("t1_count2", 64'(byte_count), 64'(2)); idle(4);
        send_byte(8'h33); check("t1_count3", 64'(byte_count), 64'(3)); idle(4);
        send_byte(8'h44);
        check("t1_count4",    64'(byte_count), 64'(4));
        check("t1_pkt_valid", 64'(pkt_valid),  64'(1));
        check("t1_pkt_data",  64'(pkt_data),   64'(32'h4433_2211));
        idle(1);
        check("t1_valid_drop", 64'(pkt_valid),  64'(0));
        check("t1_count0",     64'(byte_count), 64'(0));
        idle(3);

        // 2. Backpressure with a byte arriving during delivery.
        pkt_ready = 1'b0;
        send_byte(8'h11); idle(4);
        send_byte(8'h22); idle(4);
        send_byte(8'h33); idle(4);
        send_byte(8'h44);
        ovr = 0;
        for (int c = 1; c <= 20; c++) begin
            check("t2_pkt_valid", 64'(pkt_valid), 64'(1));
            check("t2_rx_enable", 64'(rx_enable), 64'(0));
            check("t2_pkt_data",  64'(pkt_data),  64'(32'h4433_2211));
            if (c == 3) begin
                rx_valid = 1'b1;
                rx_data  = 8'h55;
            end else begin
                rx_valid = 1'b0;
            end
            tick();
            if (overrun) ovr++;
        end
        check("t2_overrun_count", 64'(ovr), 64'(1));
        check("t2_pkt_kept", 64'(pkt_data), 64'(32'h4433_2211));
        pkt_ready = 1'b1;
        tick();
        check("t2_released", 64'(pkt_valid), 64'(0));
        idle(3);

        // 3. Timeout after a partial packet, then a normal packet.
        send_byte(8'hA1); idle(4);
        send_byte(8'hA2);
        wait_timeout(cnt);
        check("t3_latency",    64'(cnt),            64'(31));
        check("t3_byte_count", 64'(byte_count),     64'(0));
        check("t3_idle",       64'(session_active), 64'(0));
        idle(2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("t3_fresh_pkt", 64'(pkt_data), 64'(32'h0403_0201));
        idle(3);

        // 4. Activity in the final-count cycle cancels the timeout.
        send_byte(8'hB1); idle(4);
        send_byte(8'hB2);
        idle(29);
        rx_busy = 1'b1;
        tick();
        rx_busy = 1'b0;
        check("t4_no_timeout", 64'(timeout),    64'(0));
        check("t4_still_busy", 64'(byte_count), 64'(2));
        wait_timeout(cnt);
        check("t4_latency", 64'(cnt), 64'(31));
        idle(3);

        // 5. Reset mid-collect and mid-deliver.
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        idle(2);
        async_reset("t5_collect");
        idle(40);
        pkt_ready = 1'b0;
        send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3); send_byte(8'hD4);
        idle(3);
        async_reset("t5_deliver");
        idle(5);

        // Randomized traffic in phases of decreasing activity.
        last_v = 0;
        for (int ph = 0; ph < 3; ph++) begin
            int pv;
            pv = (ph == 0) ? 30 : (ph == 1) ? 6 : 2;
            for (int i = 0; i < 1200; i++) begin
                rx_valid  = !last_v && ($urandom_range(0, 99) < pv);
                rx_data   = 8'($urandom);
                rx_busy   = ($urandom_range(0, 99) < pv / 2);
                pkt_ready = ($urandom_range(0, 99) < 40);
                last_v    = rx_valid;
                tick();
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_session_ctrl.md
# rx_session_ctrl

Sequences the UART receive path into fixed-length packets and owns the inactivity timeout for a receive session. It enables the serial receiver, collects `PKT_BYTES` bytes into a packet and hands the packet to the command decoder over a valid/ready handshake. It discards a partial packet when the line stays idle for `TIMEOUT_S` seconds. It sits between the UART receiver and the packet consumer, and replaces free-running per-second timeout logic with an exact, cycle-counted timeout on the system clock.

## Interface
Parameters:
- `CLK_RATE`, default 50_000_000: sys_clk cycles per second (prescaler period).
- `TIMEOUT_S`, default 60: idle seconds before a partial packet is dropped.
- `PKT_BYTES`, default 4: bytes per packet, ≥1.

Ports:
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: one-cycle pulse; a received byte is on `rx_data`.
- `rx_data` in 8: received byte, qualified by `rx_valid`.
- `rx_busy` in 1: receiver is mid-frame (start bit seen).
- `pkt_ready` in 1: consumer accepts the packet.
- `rx_enable` out 1: enables the UART receiver.
- `pkt_valid` out 1: packet available.
- `pkt_data` out 8*PKT_BYTES: packet; first byte in [7:0].
- `byte_count` out $clog2(PKT_BYTES+1): bytes collected in current session.
- `session_active` out 1: high in COLLECT.
- `timeout` out 1: one-cycle pulse; partial packet dropped.
- `overrun` out 1: one-cycle pulse; byte arrived in DELIVER and was dropped.

## Operation
- States: IDLE, COLLECT, DELIVER. All outputs are registered.
- IDLE:
  - `rx_enable`=1.
  - On `rx_valid`, store the byte at index 0 and set `byte_count`=1.
  - Go to COLLECT. If PKT_BYTES=1, go straight to DELIVER.
- COLLECT:
  - `rx_enable`=1, `session_active`=1.
  - On `rx_valid`, store the byte at index `byte_count` and increment the count.
  - When the stored byte is number PKT_BYTES, go to DELIVER.
- DELIVER:
  - `rx_enable`=0, `pkt_valid`=1, `pkt_data` held stable.
  - On a cycle with `pkt_valid` && `pkt_ready`, go to IDLE, clear `byte_count` to 0, and drop `pkt_valid` the next cycle.
  - `rx_valid` here pulses `overrun` and the byte is discarded.
- Timeout counters (COLLECT only):
  - Prescaler is 0..CLK_RATE-1; seconds counter is 0..TIMEOUT_S-1.
  - Activity = `rx_valid` | `rx_busy`. On any activity cycle, both counters clear to 0.
  - Otherwise the prescaler increments. On prescaler wrap the seconds counter increments.
  - When prescaler = CLK_RATE-1 and seconds = TIMEOUT_S-1 with no activity:
    - `timeout` pulses.
    - Go to IDLE and clear `byte_count` to 0.
    - Contents of `pkt_data` are don't-care.
  - Both counters are held at 0 outside COLLECT.
- Widths: prescaler is $clog2(CLK_RATE); seconds counter is $clog2(TIMEOUT_S+1). There is no overflow, because counts are compared for equality before increment.

## Timing
- Reset (async assert, sync release): IDLE; `rx_enable`=1; all other outputs 0, including `pkt_data`.
- Reset mid-session or mid-DELIVER aborts immediately. No `timeout` or `overrun` pulse.
- Byte latency: `rx_valid` in cycle T → `byte_count`/state updated in cycle T+1. The last byte in T → `pkt_valid`=1 in T+1.
- Timeout: let T be the last activity cycle in COLLECT and N = TIMEOUT_S*CLK_RATE.
  - `timeout` is high in cycle T+N+1 only, and the state is IDLE in that cycle.
- Simultaneous events:
  - Activity in the final-count cycle: activity wins, no timeout. If that activity is the last byte, go to DELIVER.
  - `pkt_ready` high outside DELIVER: ignored.
  - `rx_valid` in the same cycle DELIVER completes: counts as overrun, not as a new first byte.

## Test plan
Bench parameters: CLK_RATE=10, TIMEOUT_S=3, PKT_BYTES=4.

1. **Packet capture.** Send bytes 0x11,0x22,0x33,0x44 spaced 5 cycles apart; `pkt_ready`=1.
   Expect `pkt_valid` for 1 cycle, one cycle after the 4th byte, with `pkt_data`=0x44332211. `byte_count` reads 1,2,3,4 then 0.
2. **Backpressure.** As test 1 with `pkt_ready`=0 for 20 cycles, and 0x55 pulsed in cycle 3 of DELIVER.
   Expect `pkt_valid` and `pkt_data` stable for all 20 cycles, `rx_enable`=0, `overrun` pulsed once, and the packet unchanged.
3. **Timeout.** Send 2 bytes, then leave the line idle.
   Expect `timeout` high exactly 31 cycles after the last `rx_valid`, then state IDLE with `byte_count`=0. A fresh 4-byte packet then delivers normally.
4. **Timeout boundary.** Raise `rx_busy` in the 30th idle cycle.
   Expect no timeout; the counters restart. `timeout` fires 31 cycles after that `rx_busy` cycle.
5. **Reset mid-operation.** Assert `rst_n`=0 asynchronously mid-COLLECT (3 bytes) and, separately, mid-DELIVER.
   Expect all outputs at reset values immediately, `rx_enable`=1 after release, and no `timeout` or `overrun` pulse.
